cpu_run_ctrl: RTL and testbench

Run controller for the single-cycle MIPS core. Streams a program into instruction memory through a valid/ready load port, holds the core in reset while loading, then sequences execution through run, single-step and halt commands. It sits between the host/debug interface and `mips_processor`, and drives the core's reset, clock-enable and instruction-memory write port.

---
 rtl/cpu_run_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: streams a program into instruction memory, then sequences the MIPS core
// through run / single-step / halt. Define BREAKPOINT_EN to add the PC breakpoint unit.
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              cmd_run_i,
  input  logic              cmd_step_i,
  input  logic              cmd_halt_i,
  input  logic              cmd_load_i,
  input  logic [31:0]       pc_i,
`ifdef BREAKPOINT_EN
  input  logic              bp_en_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  output logic              bp_hit_o,
`endif
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              cpu_en_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              load_ovf_o,
  output logic [31:0]       cycles_run_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HALT = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         cycles_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_waddr_q;
  logic [31:0]         imem_wdata_q;
  logic                xfer_s;
  logic                at_end_s;
  logic                bp_stop_s;
  logic                unused_pc_s;

`ifdef BREAKPOINT_EN
  logic bp_hit_q;
  logic first_run_q;

  // The first RUN cycle after HALT ignores the match so a resumed breakpoint executes.
  assign bp_stop_s   = (state_q == ST_RUN) && bp_en_i && !first_run_q &&
                       (pc_i[ADDR_W+1:2] == bp_addr_i);
  assign unused_pc_s = ^{pc_i[31:ADDR_W+2], pc_i[1:0]};
  assign bp_hit_o    = bp_hit_q;

  // Breakpoint status and resume mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bp_hit_q    <= 1'b0;
      first_run_q <= 1'b0;
    end else begin
      first_run_q <= (state_q == ST_HALT) && (state_d == ST_RUN);
      if (bp_stop_s) begin
        bp_hit_q <= 1'b1;
      end else if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
        bp_hit_q <= 1'b0;
      end
    end
  end
`else
  assign bp_stop_s   = 1'b0;
  assign unused_pc_s = ^pc_i;
`endif

  assign xfer_s   = ld_valid_i && ld_ready_o;
  assign at_end_s = (words_q[ADDR_W-1:0] == ADDR_W'(IMEM_DEPTH - 1));

  // Next-state logic: load sequencing and command decode (halt > step > run > load).
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (xfer_s) begin
          words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
          if (ld_last_i) begin
            state_d = ST_HALT;
          end else if (at_end_s) begin
            ovf_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HALT: begin
        if (cmd_halt_i) begin
          state_d = ST_HALT;
        end else if (cmd_step_i) begin
          state_d = ST_STEP;
        end else if (cmd_run_i) begin
          state_d = ST_RUN;
        end else if (cmd_load_i) begin
          state_d = ST_IDLE;
          words_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (bp_stop_s || cmd_halt_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    state_o     = 2'd0;
    cpu_reset_o = 1'b1;
    cpu_en_o    = 1'b0;
    ld_ready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_o    = 2'd0;
        ld_ready_o = 1'b1;
      end
      ST_LOAD: begin
        state_o    = 2'd1;
        ld_ready_o = 1'b1;
      end
      ST_HALT: begin
        state_o     = 2'd2;
        cpu_reset_o = 1'b0;
      end
      ST_RUN: begin
        state_o     = 2'd3;
        cpu_reset_o = 1'b0;
        cpu_en_o    = !bp_stop_s;
      end
      ST_STEP: begin
        state_o     = 2'd3;
        cpu_reset_o = 1'b0;
        cpu_en_o    = 1'b1;
      end
      default: begin
        state_o     = 2'd0;
        cpu_reset_o = 1'b1;
      end
    endcase
  end

  // State, load counters and the registered instruction-memory write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      words_q      <= '0;
      ovf_q        <= 1'b0;
      cycles_q     <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      ovf_q     <= ovf_d;
      cycles_q  <= cycles_q + {31'd0, cpu_en_o};
      imem_we_q <= xfer_s;
      if (xfer_s) begin
        imem_waddr_q <= words_q[ADDR_W-1:0];
        imem_wdata_q <= ld_data_i;
      end
    end
  end

  assign imem_we_o      = imem_we_q;
  assign imem_waddr_o   = imem_waddr_q;
  assign imem_wdata_o   = imem_wdata_q;
  assign words_loaded_o = words_q;
  assign load_ovf_o     = ovf_q;
  assign cycles_run_o   = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected memory writes and executed PCs are queued by the
// stimulus and retired by a monitor; the core is modelled as a PC that steps by 4 per enabled cycle.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid, ld_last, ld_ready;
  logic [31:0]   ld_data;
  logic          cmd_run, cmd_step, cmd_halt, cmd_load;
  logic [31:0]   pc_q;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset, cpu_en;
  logic [1:0]    state;
  logic [AW:0]   words_loaded;
  logic          load_ovf;
  logic [31:0]   cycles_run;
`ifdef BREAKPOINT_EN
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic          bp_hit;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_pc[$];
  int          n_pass  = 0;
  int          n_total = 0;

  cpu_run_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ld_ready),
    .cmd_run_i(cmd_run), .cmd_step_i(cmd_step), .cmd_halt_i(cmd_halt), .cmd_load_i(cmd_load),
    .pc_i(pc_q),
`ifdef BREAKPOINT_EN
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .bp_hit_o(bp_hit),
`endif
    .imem_we_o(imem_we), .imem_waddr_o(imem_waddr), .imem_wdata_o(imem_wdata),
    .cpu_reset_o(cpu_reset), .cpu_en_o(cpu_en), .state_o(state),
    .words_loaded_o(words_loaded), .load_ovf_o(load_ovf), .cycles_run_o(cycles_run)
  );

  always #5 clk = ~clk;

  // Core model: PC held at 0 in reset, advances one word per enabled cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc_q <= 32'd0;
    else if (cpu_reset) pc_q <= 32'd0;
    else if (cpu_en)    pc_q <= pc_q + 32'd4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: retire one expected write per strobe and one expected PC per enabled cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("write_expected", 32'(exp_wr.size()), 32'd1);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("write_addr", 32'(imem_waddr), 32'(w.addr));
        check("write_data", imem_wdata, w.data);
      end
    end
    if (cpu_en === 1'b1) begin
      if (exp_pc.size() == 0) begin
        check("cpu_en_expected", 32'(exp_pc.size()), 32'd1);
      end else begin
        check("exec_pc", pc_q, exp_pc.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_words(input int n, input logic [31:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 32'(i) * 32'h0001_0003;
      ld_last  = with_last && (i == n - 1);
      exp_wr.push_back({AW'(i), ld_data});
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'd0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cmd_load = 1'b0;
`ifdef BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    repeat (3) tick();
    sample();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_ovf", 32'(load_ovf), 32'd0);
    check("rst_cycles", cycles_run, 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // 11-word program with last on word 11
    load_words(11, 32'h1000_0000, 1'b1);
    sample();
    check("ld11_state", 32'(state), 32'd2);
    check("ld11_words", 32'(words_loaded), 32'd11);
    check("ld11_cpu_reset", 32'(cpu_reset), 32'd0);
    check("ld11_ovf", 32'(load_ovf), 32'd0);
    check("ld11_ready", 32'(ld_ready), 32'd0);
    tick();
    sample();
    check("ld11_writes_drained", 32'(exp_wr.size()), 32'd0);

    // three single steps
    for (int s = 0; s < 3; s++) begin
      exp_pc.push_back(32'(4 * s));
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      tick();
    end
    sample();
    check("step_cycles", cycles_run, 32'd3);
    check("step_pc", pc_q, 32'd12);
    check("step_state", 32'(state), 32'd2);
    check("step_pcs_drained", 32'(exp_pc.size()), 32'd0);

    // run for 20 enabled cycles; cmd_load mid-run is ignored
    for (int k = 0; k < 20; k++) exp_pc.push_back(32'd12 + 32'(4 * k));
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int k = 0; k < 19; k++) begin
      cmd_load = (k == 5);
      tick();
    end
    cmd_load = 1'b0;
    sample();
    check("run_state_mid", 32'(state), 32'd3);
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    sample();
    check("run_halt_state", 32'(state), 32'd2);
    check("run_cycles", cycles_run, 32'd23);
    check("run_pc", pc_q, 32'd92);
    check("run_cpu_en_off", 32'(cpu_en), 32'd0);
    check("run_pcs_drained", 32'(exp_pc.size()), 32'd0);

    // run+halt together while running, then while halted
    exp_pc.push_back(32'd92);
    cmd_run = 1'b1;
    tick();
    cmd_halt = 1'b1;
    tick();
    sample();
    check("runhalt_in_run", 32'(state), 32'd2);
    tick();
    cmd_run = 1'b0; cmd_halt = 1'b0;
    sample();
    check("runhalt_in_halt", 32'(state), 32'd2);
    check("runhalt_cycles", cycles_run, 32'd24);

    // step wins over run
    exp_pc.push_back(32'd96);
    cmd_step = 1'b1; cmd_run = 1'b1;
    tick();
    cmd_step = 1'b0; cmd_run = 1'b0;
    sample();
    check("steprun_state_step", 32'(state), 32'd3);
    tick();
    sample();
    check("steprun_state_halt", 32'(state), 32'd2);
    check("steprun_cycles", cycles_run, 32'd25);

    // reload, commands in IDLE ignored, then overflow with no last
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    sample();
    check("reload_state", 32'(state), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    sample();
    check("idle_ignores_run", 32'(state), 32'd0);
    load_words(16, 32'h2000_0000, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    sample();
    check("ovf_ready", 32'(ld_ready), 32'd0);
    check("ovf_flag", 32'(load_ovf), 32'd1);
    check("ovf_state", 32'(state), 32'd2);
    tick();
    tick();
    ld_valid = 1'b0;
    sample();
    check("ovf_words", 32'(words_loaded), 32'd16);
    check("ovf_writes_drained", 32'(exp_wr.size()), 32'd0);
    check("cycles_kept", cycles_run, 32'd25);

`ifdef BREAKPOINT_EN
    // breakpoint at word 9, run from 0
    bp_en = 1'b1;
    bp_addr = AW'(9);
    for (int k = 0; k < 9; k++) exp_pc.push_back(32'(4 * k));
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int t = 0; t < 40 && state != 2'd2; t++) tick();
    sample();
    check("bp_halted", 32'(state), 32'd2);
    check("bp_pc", pc_q, 32'd36);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_cycles", cycles_run, 32'd34);
    check("bp_pcs_drained", 32'(exp_pc.size()), 32'd0);
    // resume executes the breakpoint instruction
    exp_pc.push_back(32'd36);
    exp_pc.push_back(32'd40);
    exp_pc.push_back(32'd44);
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    sample();
    check("bp_hit_cleared", 32'(bp_hit), 32'd0);
    tick();
    tick();
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    sample();
    check("bp_resume_pc", pc_q, 32'd48);
    check("bp_resume_cycles", cycles_run, 32'd37);
    // a step sits on a breakpoint address and still executes
    exp_pc.push_back(32'd48);
    bp_addr = AW'(12);
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    tick();
    sample();
    check("bp_step_pc", pc_q, 32'd52);
    check("bp_step_hit", 32'(bp_hit), 32'd0);
    bp_en = 1'b0;
`endif

    // reset in the middle of a load, then a short reload
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    load_words(5, 32'h3000_0000, 1'b0);
    tick();
    sample();
    check("midload_state", 32'(state), 32'd1);
    tick();
    rst_n = 1'b0;
    sample();
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_words", 32'(words_loaded), 32'd0);
    check("async_rst_cycles", cycles_run, 32'd0);
    check("async_rst_ready", 32'(ld_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    load_words(3, 32'h4000_0000, 1'b1);
    sample();
    check("reload3_words", 32'(words_loaded), 32'd3);
    check("reload3_state", 32'(state), 32'd2);
    tick();
    sample();
    check("reload3_writes_drained", 32'(exp_wr.size()), 32'd0);
    check("final_pcs_drained", 32'(exp_pc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
